mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store initiator between the MEM pipeline stage and the byte-addressed data RAM. It accepts one load or store request at a time from the pipeline and drives the RAM's chip-enable, write-enable, address, byte-select and write-data lines. It aligns and sign- or zero-extends read data, detects misaligned accesses, and stalls the pipeline while an access is in flight. The RAM side is little-endian: byte-select bit k corresponds to byte k, which is data bits [8k+7:8k].

## Interface
- No parameters. Data and address width is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_i  in  1  access request from the MEM stage; sampled only in IDLE.
- op_i  in  3  operation:
  - 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW
  - 101 SB, 110 SH, 111 SW
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- stall_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle pulse marking access completion.
- rdata_o  out  32  extended load result; valid while done_o=1.
- misalign_o  out  1  valid while done_o=1; access was misaligned and suppressed.
- mem_ce_o  out  1  RAM chip enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  32  RAM address, low 2 bits forced to 00.
- mem_sel_o  out  4  RAM byte-lane select.
- mem_data_o  out  32  RAM write data.
- mem_data_i  in  32  RAM read data; combinational from the RAM.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, req_i=1, aligned:
  - Register op, addr[1:0] and the RAM drive values.
  - Go to ACCESS.
- IDLE, req_i=1, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠00):
  - Go directly to RESP with misalign=1 and rdata=0.
  - No RAM cycle: mem_ce_o stays 0.
- ACCESS:
  - mem_ce_o=1.
  - mem_we_o=1 for stores.
  - At the edge: capture the extended load data (0 for stores), then go to RESP.
  - The RAM commits stores at this same edge.
- RESP: done_o=1; go to IDLE unconditionally. req_i is ignored in RESP.
- Requester contract: hold req_i and inputs stable until done_o. Drop req_i, or present a new request, in the cycle after done_o. A still-asserted req_i in IDLE starts a new access.
- Byte lanes, with k = addr[1:0]:
  - Byte op: sel = 1<<k.
  - Half op: sel = 0011 (k=0) or 1100 (k=2).
  - Word op: sel = 1111.
  - Loads use the same sel value.
- Store data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extension:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend the selected lane.
  - LW passes mem_data_i unchanged.
- RAM outputs are registered. In IDLE and RESP, mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o and mem_data_o are all 0.

## Timing
- Reset: state=IDLE, all outputs 0, captured data cleared. Reset takes effect immediately, without waiting for a clock edge.
- Reset asserted in ACCESS: mem_ce_o and mem_we_o drop to 0 at once, so no store commits at the next edge. The aborted access produces no done_o.
- Aligned access latency: request sampled at edge E0, ACCESS for the cycle E0–E1, done_o for the cycle E1–E2, back in IDLE at E2.
- Misaligned access: done_o and misalign_o high for the cycle E0–E1.
- stall_o is combinational: (state==IDLE && req_i) || state==ACCESS. It is low in RESP so the pipeline advances with the result.
- Throughput: one access per 3 cycles (aligned) or per 2 cycles (misaligned).

## Test plan
- Store then load word: SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10.
  - Store cycle: ACCESS with sel=1111, we=1.
  - Load: rdata_o=0xDEADBEEF with done_o=1 exactly 2 cycles after acceptance.
  - stall_o=1 for the 2 cycles before done_o.
- Byte lanes: with word 0x80FF7F01 at 0x20:
  - LB 0x20 -> 0x00000001
  - LB 0x23 -> 0xFFFFFF80
  - LBU 0x23 -> 0x00000080
  - LB 0x21 -> 0x0000007F
- Halfword and sub-word stores:
  - SH 0x22 wdata=0x1234ABCD -> sel=1100, mem_data_o=0xABCDABCD.
  - LH 0x22 -> 0xFFFFABCD; LHU 0x22 -> 0x0000ABCD.
  - SB 0x21 wdata=0x55 -> sel=0010; the other bytes are unchanged on LW.
- Misalignment:
  - LW 0x02 -> done_o and misalign_o on the cycle after acceptance, rdata_o=0, mem_ce_o never 1.
  - SH 0x05 -> same response; a following LW of that word is unchanged.
- Reset mid-store: assert rst while in ACCESS for SW 0x30 0xCAFEF00D.
  - mem_ce_o drops immediately and no done_o is produced.
  - After release, LW 0x30 returns the prior contents.
- Back-to-back: req_i held high across a done_o.
  - A second access is accepted in the IDLE cycle after RESP.
  - done_o pulses are separated by exactly 3 cycles.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and a byte-addressed data RAM.
// Latency: aligned access done 2 cycles after acceptance, misaligned after 1; stall_o holds the pipeline meanwhile.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_op;
    logic [1:0]  r_k;
    logic        r_mem_ce;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_sel;
    logic [31:0] r_mem_data;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_is_store;
    logic        w_misalign;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load_ext;

    assign w_is_byte  = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
    assign w_is_half  = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
    assign w_is_word  = (op_i == OP_LW) || (op_i == OP_SW);
    assign w_is_store = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW);
    assign w_misalign = (w_is_half && addr_i[0]) || (w_is_word && (addr_i[1:0] != 2'b00));

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = wdata_i;
        if (w_is_byte) begin
            w_sel   = 4'b0001 << addr_i[1:0];
            w_wdata = {4{wdata_i[7:0]}};
        end else if (w_is_half) begin
            w_sel   = addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata_i[15:0]}};
        end
    end

    // Lane selection works from the offset registered at acceptance.
    always_comb begin
        case (r_k)
            2'd0:    w_lane_b = mem_data_i[7:0];
            2'd1:    w_lane_b = mem_data_i[15:8];
            2'd2:    w_lane_b = mem_data_i[23:16];
            default: w_lane_b = mem_data_i[31:24];
        endcase
        w_lane_h = r_k[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        case (r_op)
            OP_LB:   w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
            OP_LBU:  w_load_ext = {24'd0, w_lane_b};
            OP_LH:   w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
            OP_LHU:  w_load_ext = {16'd0, w_lane_h};
            OP_LW:   w_load_ext = mem_data_i;
            default: w_load_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_i) w_next = w_misalign ? S_RESP : S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o = ((r_state == S_IDLE) && req_i) || (r_state == S_ACCESS);
        done_o  = (r_state == S_RESP);
    end

    // RAM drive is registered so the async reset pulls ce/we low mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_k        <= 2'd0;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_mem_sel  <= 4'd0;
            r_mem_data <= 32'd0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_op <= op_i;
                        r_k  <= addr_i[1:0];
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_rdata    <= 32'd0;
                        end else begin
                            r_misalign <= 1'b0;
                            r_mem_ce   <= 1'b1;
                            r_mem_we   <= w_is_store;
                            r_mem_addr <= {addr_i[31:2], 2'b00};
                            r_mem_sel  <= w_sel;
                            r_mem_data <= w_is_store ? w_wdata : 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_rdata    <= w_load_ext;
                    r_mem_ce   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= 32'd0;
                    r_mem_sel  <= 4'd0;
                    r_mem_data <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign rdata_o    = r_rdata;
    assign misalign_o = r_misalign;
    assign mem_ce_o   = r_mem_ce;
    assign mem_we_o   = r_mem_we;
    assign mem_addr_o = r_mem_addr;
    assign mem_sel_o  = r_mem_sel;
    assign mem_data_o = r_mem_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array memory model plus a word RAM driven by the DUT.
module tb_mem_access_ctrl;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4,
                           SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o, done_o, misalign_o, mem_ce_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_sel_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:63];
    logic [7:0]  mm  [0:255];

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        logic        stall_pre;
        logic        stall_acc;
        logic        stall_done;
        logic        ce_seen;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic        timeout;
    } obs_t;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce_o && mem_we_o)
            for (int k = 0; k < 4; k++)
                if (mem_sel_o[k]) ram[mem_addr_o[7:2]][8*k +: 8] <= mem_data_o[8*k +: 8];
    end
    assign mem_data_i = ram[mem_addr_o[7:2]];

    function automatic logic is_store(input logic [2:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return a[0];
        if (op == LW || op == SW) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [2:0] op, input logic [31:0] a);
        if (op == LB || op == LBU || op == SB) return 4'(1 << a[1:0]);
        if (op == LH || op == LHU || op == SH) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] w);
        if (op == SB) return {4{w[7:0]}};
        if (op == SH) return {2{w[15:0]}};
        if (op == SW) return w;
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
        int b;
        logic [7:0]  by;
        logic [15:0] hw;
        b  = int'(a[7:0]);
        by = mm[b];
        hw = {mm[(b + 1) % 256], mm[b]};
        case (op)
            LB:  return {{24{by[7]}}, by};
            LBU: return {24'd0, by};
            LH:  return {{16{hw[15]}}, hw};
            LHU: return {16'd0, hw};
            LW:  return {mm[(b + 3) % 256], mm[(b + 2) % 256], hw};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        int b;
        int n;
        b = int'(a[7:0]);
        n = (op == SB) ? 1 : (op == SH) ? 2 : 4;
        for (int i = 0; i < n; i++) mm[(b + i) % 256] = w[8*i +: 8];
    endtask

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic do_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                             output obs_t o);
        req_i = 1'b1; op_i = op; addr_i = a; wdata_i = w;
        #1;
        o.stall_pre = stall_o;
        o.ce_seen = 1'b0; o.lat = 0; o.timeout = 1'b1; o.we = 1'b0; o.sel = 4'd0;
        o.maddr = 32'd0; o.mdata = 32'd0; o.stall_acc = 1'b0; o.stall_done = 1'b0;
        o.rdata = 32'd0; o.mis = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_ce_o) begin
                o.ce_seen = 1'b1; o.we = mem_we_o; o.sel = mem_sel_o;
                o.maddr = mem_addr_o; o.mdata = mem_data_o; o.stall_acc = stall_o;
            end
            if (done_o) begin
                o.lat = c; o.rdata = rdata_o; o.mis = misalign_o;
                o.stall_done = stall_o; o.timeout = 1'b0;
                break;
            end
        end
        req_i = 1'b0;
        if (!o.timeout && is_store(op) && !misaligned(op, a)) model_store(op, a, w);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = 1'b0; op_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
        #1;
        checks++;
        if ({stall_o, done_o, misalign_o, mem_ce_o, mem_we_o} !== 5'd0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {stall_o, done_o, misalign_o, mem_ce_o, mem_we_o});
        end
        checks++;
        if ({rdata_o, mem_addr_o, mem_data_o, mem_sel_o} !== 100'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h exp zeros", rdata_o, mem_addr_o, mem_data_o, mem_sel_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_idle_done got %b exp 0", done_o); end
    endtask

    task automatic test_preload();
        obs_t o;
        for (int i = 0; i < 64; i++) do_access(SW, 32'(i * 4), 32'd0, o);
        checks++;
        if (o.timeout !== 1'b0) begin errors++; $display("FAIL preload_timeout got %b exp 0", o.timeout); end
    endtask

    task automatic test_store_load_word();
        obs_t o;
        do_access(SW, 32'h10, 32'hDEADBEEF, o);
        checks++;
        if ({o.ce_seen, o.we, o.sel} !== 6'b11_1111) begin
            errors++; $display("FAIL sw_access got ce=%b we=%b sel=%b exp 1 1 1111", o.ce_seen, o.we, o.sel);
        end
        checks++;
        if (o.maddr !== 32'h10 || o.mdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_bus got %h %h exp 00000010 deadbeef", o.maddr, o.mdata);
        end
        do_access(LW, 32'h10, 32'h0, o);
        checks++;
        if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", o.rdata); end
        checks++;
        if (o.lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", o.lat); end
        checks++;
        if ({o.stall_pre, o.stall_acc, o.stall_done, o.we} !== 4'b1100) begin
            errors++; $display("FAIL lw_stall got pre=%b acc=%b done=%b we=%b exp 1 1 0 0",
                               o.stall_pre, o.stall_acc, o.stall_done, o.we);
        end
    endtask

    task automatic test_byte_lanes();
        obs_t o;
        logic [2:0]  t_op  [4] = '{LB, LB, LBU, LB};
        logic [31:0] t_adr [4] = '{32'h20, 32'h23, 32'h23, 32'h21};
        logic [31:0] t_exp [4] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'h0000007F};
        do_access(SW, 32'h20, 32'h80FF7F01, o);
        for (int i = 0; i < 4; i++) begin
            do_access(t_op[i], t_adr[i], 32'h0, o);
            checks++;
            if (o.rdata !== t_exp[i] || o.sel !== 4'(1 << t_adr[i][1:0])) begin
                errors++; $display("FAIL byte_lane_%0d got %h sel %b exp %h sel %b", i, o.rdata, o.sel,
                                   t_exp[i], 4'(1 << t_adr[i][1:0]));
            end
        end
    endtask

    task automatic test_halfword();
        obs_t o;
        do_access(SH, 32'h22, 32'h1234ABCD, o);
        checks++;
        if (o.sel !== 4'b1100 || o.mdata !== 32'hABCDABCD) begin
            errors++; $display("FAIL sh_bus got sel %b data %h exp 1100 abcdabcd", o.sel, o.mdata);
        end
        do_access(LH, 32'h22, 32'h0, o);
        checks++;
        if (o.rdata !== 32'hFFFFABCD) begin errors++; $display("FAIL lh got %h exp ffffabcd", o.rdata); end
        do_access(LHU, 32'h22, 32'h0, o);
        checks++;
        if (o.rdata !== 32'h0000ABCD) begin errors++; $display("FAIL lhu got %h exp 0000abcd", o.rdata); end
        do_access(SB, 32'h21, 32'h55, o);
        checks++;
        if (o.sel !== 4'b0010 || o.mdata !== 32'h55555555) begin
            errors++; $display("FAIL sb_bus got sel %b data %h exp 0010 55555555", o.sel, o.mdata);
        end
        do_access(LW, 32'h20, 32'h0, o);
        checks++;
        if (o.rdata !== 32'hABCD5501) begin errors++; $display("FAIL sb_merge got %h exp abcd5501", o.rdata); end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_access(LW, 32'h02, 32'h0, o);
        checks++;
        if ({o.mis, o.ce_seen} !== 2'b10 || o.rdata !== 32'd0 || o.lat !== 1) begin
            errors++; $display("FAIL lw_misalign got mis=%b ce=%b rdata=%h lat=%0d exp 1 0 0 1",
                               o.mis, o.ce_seen, o.rdata, o.lat);
        end
        do_access(SW, 32'h04, 32'h11223344, o);
        do_access(SH, 32'h05, 32'hFFFF, o);
        checks++;
        if ({o.mis, o.ce_seen} !== 2'b10 || o.lat !== 1 || o.stall_done !== 1'b0) begin
            errors++; $display("FAIL sh_misalign got mis=%b ce=%b lat=%0d stall=%b exp 1 0 1 0",
                               o.mis, o.ce_seen, o.lat, o.stall_done);
        end
        do_access(LW, 32'h04, 32'h0, o);
        checks++;
        if (o.rdata !== 32'h11223344) begin errors++; $display("FAIL sh_misalign_nowrite got %h exp 11223344", o.rdata); end
    endtask

    task automatic test_reset_mid_store();
        obs_t o;
        int pulses;
        do_access(SW, 32'h30, 32'h01020304, o);
        req_i = 1'b1; op_i = SW; addr_i = 32'h30; wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (mem_ce_o !== 1'b1) begin errors++; $display("FAIL rst_pre_access got ce=%b exp 1", mem_ce_o); end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_ce_o, mem_we_o, done_o} !== 3'b000) begin
            errors++; $display("FAIL rst_abort got ce/we/done %b exp 000", {mem_ce_o, mem_we_o, done_o});
        end
        req_i = 1'b0;
        pulses = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done_o) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL rst_no_done got %0d pulses exp 0", pulses); end
        do_access(LW, 32'h30, 32'h0, o);
        checks++;
        if (o.rdata !== 32'h01020304) begin errors++; $display("FAIL rst_no_commit got %h exp 01020304", o.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int c1, gap;
        w = $urandom;
        c1 = 0; gap = 0;
        req_i = 1'b1; op_i = SW; addr_i = 32'h40; wdata_i = w;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done_o) begin c1 = c; break; end
        end
        op_i = LW; wdata_i = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done_o) begin gap = c; break; end
        end
        checks++;
        if (c1 !== 2 || gap !== 3) begin errors++; $display("FAIL b2b_spacing got lat=%0d gap=%0d exp 2 3", c1, gap); end
        checks++;
        if (rdata_o !== w) begin errors++; $display("FAIL b2b_data got %h exp %h", rdata_o, w); end
        model_store(SW, 32'h40, w);
        req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0]  op;
        logic [31:0] a, w, er;
        logic        em;
        int          bad;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            w  = $urandom;
            em = misaligned(op, a);
            er = (em || is_store(op)) ? 32'd0 : model_load(op, a);
            do_access(op, a, w, o);
            checks++;
            if (o.timeout || o.rdata !== er || o.mis !== em || o.lat !== (em ? 1 : 2) || o.ce_seen !== !em) begin
                errors++; bad++;
                $display("FAIL rand_resp_%0d op=%0d addr=%h got rdata=%h mis=%b lat=%0d ce=%b exp %h %b %0d %b",
                         i, op, a, o.rdata, o.mis, o.lat, o.ce_seen, er, em, em ? 1 : 2, !em);
            end
            if (!em) begin
                checks++;
                if (o.we !== is_store(op) || o.sel !== exp_sel(op, a) || o.maddr !== {a[31:2], 2'b00} ||
                    o.mdata !== exp_wdata(op, w)) begin
                    errors++; bad++;
                    $display("FAIL rand_bus_%0d got we=%b sel=%b addr=%h data=%h exp %b %b %h %h", i, o.we,
                             o.sel, o.maddr, o.mdata, is_store(op), exp_sel(op, a), {a[31:2], 2'b00}, exp_wdata(op, w));
                end
            end
            if (bad > 5) break;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = 8'd0;
        test_reset();
        test_preload();
        test_store_load_word();
        test_byte_lanes();
        test_halfword();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
